mem_access_unit: RTL and testbench

//  Requester side of the single-port block memory: turns core load/store requests
//  (RISC-V funct3 sizes, byte addresses) into word accesses on the memory port
//  (MEM_ENABLED/ADDRESS/WRITE_ENABLE/WRITE_DATA, 1-cycle registered READ_DATA).

---
 rtl/mem_access_unit_if.sv | 32 +++
 rtl/mem_access_unit.sv | 132 +++++++++++++
 tb/tb_mem_access_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bundle of the core-facing request/response channel and the block-memory port.
// The slave modport is the access unit's view; master is the core and memory side.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_error;
  logic                  mem_enabled;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_write_enable;
  logic [31:0]           mem_write_data;
  logic [31:0]           mem_read_data;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
           mem_enabled, mem_address, mem_write_enable, mem_write_data
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           mem_enabled, mem_address, mem_write_enable, mem_write_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store requester for a single-port block memory with 1-cycle registered reads.
// Handles sub-word stores by read-modify-write and sub-word loads by lane extraction.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  mem_access_unit_if.slave        bus
);
  typedef enum logic [1:0] {IDLE, LOAD_DATA, RMW_WRITE, RESP} state_e;

  state_e                state_q, state_d;
  logic                  write_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [15:0]           wdata_q;
  logic [31:0]           rdata_q, rdata_d;
  logic                  error_q, error_d;

  logic                  accept;
  logic                  req_err;
  logic                  mem_en, mem_we;
  logic [31:0]           mem_wdata;
  logic [31:0]           merged;
  logic                  unused_addr_bits;

  function automatic logic req_illegal(input logic wr, input logic [2:0] f3, input logic [1:0] a);
    logic bad_f3, misal;
    bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (wr && f3[2]);
    misal  = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    return bad_f3 || misal;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'b0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'b0, h};
      default: return word;
    endcase
  endfunction

  assign unused_addr_bits = ^bus.req_addr[31:ADDR_WIDTH+2];

  assign bus.req_ready = rst_ni && (state_q == IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign req_err       = req_illegal(bus.req_write, bus.req_funct3, bus.req_addr[1:0]);

  // Store data replaces the addressed byte/half lane of the old word read last cycle.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic hit;
    assign hit = funct3_q[0] ? (addr_q[1] == 1'(gi / 2)) : (addr_q[1:0] == 2'(gi));
    assign merged[gi*8 +: 8] = hit ? (funct3_q[0] ? wdata_q[(gi % 2)*8 +: 8] : wdata_q[7:0])
                                   : bus.mem_read_data[gi*8 +: 8];
  end

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = bus.req_wdata;
    case (state_q)
      IDLE: begin
        if (accept) begin
          error_d = req_err;
          rdata_d = 32'b0;
          if (req_err) begin
            state_d = RESP;
          end else if (bus.req_write && (bus.req_funct3 == 3'b010)) begin
            mem_en  = 1'b1;
            mem_we  = 1'b1;
            state_d = RESP;
          end else begin
            mem_en  = 1'b1;
            state_d = bus.req_write ? RMW_WRITE : LOAD_DATA;
          end
        end
      end
      LOAD_DATA: begin
        rdata_d = load_extract(bus.mem_read_data, funct3_q, addr_q[1:0]);
        state_d = RESP;
      end
      RMW_WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = merged;
        state_d   = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      funct3_q <= 3'b0;
      addr_q   <= '0;
      wdata_q  <= 16'b0;
      rdata_q  <= 32'b0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      if (accept) begin
        write_q  <= bus.req_write;
        funct3_q <= bus.req_funct3;
        addr_q   <= bus.req_addr[ADDR_WIDTH+1:0];
        wdata_q  <= bus.req_wdata[15:0];
      end
    end
  end

  assign bus.mem_enabled      = mem_en && rst_ni;
  assign bus.mem_write_enable = mem_we && rst_ni && (write_q || state_q == IDLE);
  assign bus.mem_write_data   = mem_wdata;
  assign bus.mem_address      = (state_q == IDLE) ? bus.req_addr[ADDR_WIDTH+1:2]
                                                  : addr_q[ADDR_WIDTH+1:2];
  assign bus.resp_valid       = (state_q == RESP);
  assign bus.resp_rdata       = rdata_q;
  assign bus.resp_error       = error_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: the driver queues the expected response per request, a negedge
// monitor pops and compares on every RESP_VALID; a behavioural block memory closes the loop.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  mem_access_unit_if #(.ADDR_WIDTH(10)) bus();
  mem_access_unit #(.ADDR_WIDTH(10)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.mem_enabled) begin
      if (bus.mem_write_enable) mem[bus.mem_address] <= bus.mem_write_data;
      bus.mem_read_data <= mem[bus.mem_address];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (bus.resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual rdata=0x%08h err=%0b required none",
                 bus.resp_rdata, bus.resp_error);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("resp cyc=%0d rdata=0x%08h err=%0b", cyc, bus.resp_rdata, bus.resp_error);
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_error", 32'(bus.resp_error), 32'(e.err));
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] er, input logic ee,
                     input int lat, output logic en0, output logic we0,
                     output logic en1, output logic we1, output logic [9:0] ad0);
    int n;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=not_ready required=ready");
    end
    #1;
    en0 = bus.mem_enabled;
    we0 = bus.mem_write_enable;
    ad0 = bus.mem_address;
    exp_q.push_back('{er, ee, cyc + lat});
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    en1 = bus.mem_enabled;
    we1 = bus.mem_write_enable;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic go(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] wd, input logic [31:0] er, input logic ee, input int lat);
    logic e0, w0, e1, w1;
    logic [9:0] ad;
    req(wr, f3, a, wd, er, ee, lat, e0, w0, e1, w1, ad);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e0, w0, e1, w1;
    logic [9:0] ad;
    bus.req_valid     = 1'b1;
    bus.req_write     = 1'b0;
    bus.req_funct3    = 3'b010;
    bus.req_addr      = 32'h10;
    bus.req_wdata     = 32'h0;
    bus.mem_read_data = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_mem_en", 32'(bus.mem_enabled), 32'h0);
    chk("rst_mem_we", 32'(bus.mem_write_enable), 32'h0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_resp_error", 32'(bus.resp_error), 32'h0);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;

    // Word store then load
    req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1, e0, w0, e1, w1, ad);
    chk("sw_en", 32'(e0), 32'h1);
    chk("sw_we", 32'(w0), 32'h1);
    go(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Byte store by read-modify-write
    go(1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0, 1'b0, 1);
    req(1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 1'b0, 2, e0, w0, e1, w1, ad);
    chk("sb_t_en", 32'(e0), 32'h1);
    chk("sb_t_we", 32'(w0), 32'h0);
    chk("sb_t1_en", 32'(e1), 32'h1);
    chk("sb_t1_we", 32'(w1), 32'h1);
    chk("sb_word", mem[4], 32'hA5223344);
    go(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFA5, 1'b0, 2);
    go(1'b0, 3'b100, 32'h13, 32'h0, 32'h000000A5, 1'b0, 2);

    // Half stores and loads
    go(1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0, 1'b0, 1);
    go(1'b1, 3'b001, 32'h12, 32'h00008001, 32'h0, 1'b0, 2);
    chk("sh_hi_word", mem[4], 32'h80013344);
    go(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8001, 1'b0, 2);
    go(1'b0, 3'b101, 32'h12, 32'h0, 32'h00008001, 1'b0, 2);
    go(1'b1, 3'b001, 32'h10, 32'h00007FFF, 32'h0, 1'b0, 2);
    go(1'b0, 3'b010, 32'h10, 32'h0, 32'h80017FFF, 1'b0, 2);

    // Misaligned and illegal requests
    go(1'b1, 3'b010, 32'h10, 32'h55667788, 32'h0, 1'b0, 1);
    req(1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1, 1, e0, w0, e1, w1, ad);
    chk("err_lw_en", 32'({e0, e1}), 32'h0);
    req(1'b1, 3'b001, 32'h13, 32'hFFFF, 32'h0, 1'b1, 1, e0, w0, e1, w1, ad);
    chk("err_sh_en", 32'({e0, e1}), 32'h0);
    req(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, e0, w0, e1, w1, ad);
    chk("err_f3_011_en", 32'({e0, e1}), 32'h0);
    req(1'b1, 3'b100, 32'h10, 32'hFF, 32'h0, 1'b1, 1, e0, w0, e1, w1, ad);
    chk("err_sbu_en", 32'({e0, e1}), 32'h0);
    go(1'b0, 3'b010, 32'h10, 32'h0, 32'h55667788, 1'b0, 2);

    // Address wrap above the index width
    req(1'b1, 3'b010, 32'h1000, 32'hCAFEF00D, 32'h0, 1'b0, 1, e0, w0, e1, w1, ad);
    chk("wrap_addr", 32'(ad), 32'h0);
    go(1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, 2);

    // Reset during the RMW write cycle aborts the store
    go(1'b1, 3'b010, 32'h20, 32'h01020304, 32'h0, 1'b0, 1);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'hEE;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ready_low", 32'(bus.req_ready), 32'h0);
    chk("abort_mem_we", 32'(bus.mem_write_enable), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_ready_high", 32'(bus.req_ready), 32'h1);
    chk("abort_word", mem[8], 32'h01020304);
    go(1'b0, 3'b010, 32'h20, 32'h0, 32'h01020304, 1'b0, 2);

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
